// File: rtl/ecc_73_pkg.sv
// Shared definitions for the ECC(73) error monitor.
// Holds the default widths used by the monitor's parameters and the scrub-request
// state enum (used only when the monitor is built with ECC_73_SCRUB_EN).
package ecc_73_pkg;

  localparam int unsigned DefDataWidth = 73;
  localparam int unsigned DefAddrWidth = 10;
  localparam int unsigned DefCntWidth  = 16;

  // Scrub request FSM: StIdle waits for a correctable beat, StReq presents it.
  typedef enum logic {
    StIdle = 1'b0,
    StReq  = 1'b1
  } scrub_st_e;

endpackage

// File: rtl/ecc_73_skid_buf.sv
// Two-entry valid/ready buffer with registered outputs.
// An accepted beat appears on out_* the cycle after acceptance. in_rdy_o is low while
// both entries are occupied and while rst_i is high.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_vld_i/in_rdy_o/in_data_i  upstream handshake and payload
//   out_vld_o/out_rdy_i/out_data_o downstream handshake and payload (zero when empty)
module ecc_73_skid_buf #(
  parameter int unsigned Width = 74
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [Width-1:0] out_data_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  // Readiness depends only on registered occupancy, so a full buffer drops in_rdy_o
  // the cycle after the second entry is written.
  assign in_rdy_o   = ~rst_i & (cnt_q != 2'd2);
  assign out_vld_o  = (cnt_q != 2'd0);
  assign out_data_o = out_vld_o ? mem_q[rd_ptr_q] : '0;

  assign push = in_vld_i & in_rdy_o;
  assign pop  = out_vld_o & out_rdy_i;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ecc_73_err_monitor.sv
// ECC(73) error monitor.
// Passes corrected read beats through a 2-entry buffer (1-cycle latency), flags beats that
// carried an uncorrectable error or fault, keeps saturating error counters, latches the
// address of the first uncorrectable/fault beat and raises irq while it is latched.
// Optional (macro ECC_73_SCRUB_EN): a scrub request port that presents the address/data of
// a single-bit-corrected beat for write-back; extra eligible beats while one is pending
// are dropped and flagged via sticky scrub_ovf.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   in_vld/in_rdy/in_data/in_addr       input beat handshake, corrected data, read address
//   in_sbit/in_dbit/in_fault            error flags of the input beat
//   out_vld/out_rdy/out_data/out_err    output beat; out_err = dbit | fault of that beat
//   sbit_cnt/dbit_cnt/fault_cnt         saturating error counters
//   first_addr/first_vld, irq           first uncorrectable-error capture and interrupt
//   clr                                 one-cycle clear of counters, first_vld, irq, scrub_ovf
//   scrub_vld/scrub_rdy/scrub_addr/scrub_data/scrub_ovf   scrub request (ECC_73_SCRUB_EN only)
module ecc_73_err_monitor
  import ecc_73_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_sbit,
  input  logic                  in_dbit,
  input  logic                  in_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] first_addr,
  output logic                  first_vld,
  input  logic                  clr,
`ifdef ECC_73_SCRUB_EN
  output logic                  scrub_vld,
  input  logic                  scrub_rdy,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic [DATA_WIDTH-1:0] scrub_data,
  output logic                  scrub_ovf,
`endif
  output logic                  irq
);

  localparam int unsigned PayWidth = DATA_WIDTH + 1;

  logic acc, err_beat;

  assign acc      = in_vld & in_rdy;
  assign err_beat = acc & (in_dbit | in_fault);

  ecc_73_skid_buf #(
    .Width (PayWidth)
  ) u_skid_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .in_data_i  ({in_dbit | in_fault, in_data}),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .out_data_o ({out_err, out_data})
  );

  // Counters and first-error capture. clr is applied before the current beat so an
  // error accepted alongside clr is still recorded.
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
  logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
  logic                  first_vld_q, first_vld_d, first_vld_base, irq_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && !(&v)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  always_comb begin
    sbit_cnt_d     = sat_inc(clr ? '0 : sbit_cnt_q, acc & in_sbit & ~in_dbit);
    dbit_cnt_d     = sat_inc(clr ? '0 : dbit_cnt_q, acc & in_dbit);
    fault_cnt_d    = sat_inc(clr ? '0 : fault_cnt_q, acc & in_fault);
    first_vld_base = first_vld_q & ~clr;
    first_vld_d    = first_vld_base | err_beat;
    first_addr_d   = (err_beat && !first_vld_base) ? in_addr : first_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt_q   <= '0;
      dbit_cnt_q   <= '0;
      fault_cnt_q  <= '0;
      first_addr_q <= '0;
      first_vld_q  <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      sbit_cnt_q   <= sbit_cnt_d;
      dbit_cnt_q   <= dbit_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
      first_addr_q <= first_addr_d;
      first_vld_q  <= first_vld_d;
      irq_q        <= first_vld_d;
    end
  end

  assign sbit_cnt   = sbit_cnt_q;
  assign dbit_cnt   = dbit_cnt_q;
  assign fault_cnt  = fault_cnt_q;
  assign first_addr = first_addr_q;
  assign first_vld  = first_vld_q;
  assign irq        = irq_q;

`ifdef ECC_73_SCRUB_EN
  scrub_st_e             st_q, st_d;
  logic [ADDR_WIDTH-1:0] scrub_addr_q, scrub_addr_d;
  logic [DATA_WIDTH-1:0] scrub_data_q, scrub_data_d;
  logic                  scrub_ovf_q, scrub_ovf_d;
  logic                  scrub_elig;

  // Only purely correctable beats are worth writing back.
  assign scrub_elig = acc & in_sbit & ~in_dbit & ~in_fault;

  always_comb begin
    st_d         = st_q;
    scrub_addr_d = scrub_addr_q;
    scrub_data_d = scrub_data_q;
    scrub_ovf_d  = scrub_ovf_q & ~clr;
    case (st_q)
      StIdle: begin
        if (scrub_elig) begin
          scrub_addr_d = in_addr;
          scrub_data_d = in_data;
          st_d         = StReq;
        end
      end
      StReq: begin
        // A pending request is never replaced; extra candidates are only reported.
        if (scrub_elig) begin
          scrub_ovf_d = 1'b1;
        end
        if (scrub_rdy) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= StIdle;
      scrub_addr_q <= '0;
      scrub_data_q <= '0;
      scrub_ovf_q  <= 1'b0;
    end else begin
      st_q         <= st_d;
      scrub_addr_q <= scrub_addr_d;
      scrub_data_q <= scrub_data_d;
      scrub_ovf_q  <= scrub_ovf_d;
    end
  end

  assign scrub_vld  = (st_q == StReq);
  assign scrub_addr = scrub_addr_q;
  assign scrub_data = scrub_data_q;
  assign scrub_ovf  = scrub_ovf_q;
`endif

endmodule

// File: tb/tb_ecc_73_err_monitor.sv
// Bench for ecc_73_err_monitor: directed scenarios plus a randomized phase, all checked
// every cycle against a queue-based behavioural model. Scrub checks compile only when
// ECC_73_SCRUB_EN is defined.
module tb_ecc_73_err_monitor;

  localparam int unsigned DW = 73;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, in_rdy;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_sbit = 1'b0, in_dbit = 1'b0, in_fault = 1'b0;
  logic          out_vld, out_rdy = 1'b1, out_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [AW-1:0] first_addr;
  logic          first_vld, irq, clr = 1'b0;
`ifdef ECC_73_SCRUB_EN
  logic          scrub_vld, scrub_rdy = 1'b0, scrub_ovf;
  logic [AW-1:0] scrub_addr;
  logic [DW-1:0] scrub_data;
`endif

  always #5 clk = ~clk;

  ecc_73_err_monitor #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .in_sbit    (in_sbit),
    .in_dbit    (in_dbit),
    .in_fault   (in_fault),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_err    (out_err),
    .sbit_cnt   (sbit_cnt),
    .dbit_cnt   (dbit_cnt),
    .fault_cnt  (fault_cnt),
    .first_addr (first_addr),
    .first_vld  (first_vld),
    .clr        (clr),
`ifdef ECC_73_SCRUB_EN
    .scrub_vld  (scrub_vld),
    .scrub_rdy  (scrub_rdy),
    .scrub_addr (scrub_addr),
    .scrub_data (scrub_data),
    .scrub_ovf  (scrub_ovf),
`endif
    .irq        (irq)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } beat_t;

  beat_t         q[$];
  bit            live = 0;
  int            m_sbit, m_dbit, m_fault;
  bit            m_first_vld;
  logic [AW-1:0] m_first_addr;
  bit            m_sreq, m_ovf;
  logic [AW-1:0] m_saddr;
  logic [DW-1:0] m_sdata;

  always @(posedge clk) begin
    bit acc;
    beat_t b;
    if (rst) begin
      q.delete();
      m_sbit = 0; m_dbit = 0; m_fault = 0;
      m_first_vld = 0; m_first_addr = '0;
      m_sreq = 0; m_ovf = 0; m_saddr = '0; m_sdata = '0;
      live = 1;
    end else begin
      acc = in_vld && (q.size() < 2);
      if (q.size() != 0 && out_rdy) void'(q.pop_front());
      if (acc) begin
        b.data = in_data;
        b.err  = in_dbit | in_fault;
        q.push_back(b);
      end
      if (clr) begin
        m_sbit = 0; m_dbit = 0; m_fault = 0; m_first_vld = 0; m_ovf = 0;
      end
      if (acc) begin
        if (in_sbit && !in_dbit && m_sbit < CntMax) m_sbit++;
        if (in_dbit && m_dbit < CntMax) m_dbit++;
        if (in_fault && m_fault < CntMax) m_fault++;
        if ((in_dbit || in_fault) && !m_first_vld) begin
          m_first_vld  = 1;
          m_first_addr = in_addr;
        end
      end
`ifdef ECC_73_SCRUB_EN
      if (!m_sreq) begin
        if (acc && in_sbit && !in_dbit && !in_fault) begin
          m_sreq = 1; m_saddr = in_addr; m_sdata = in_data;
        end
      end else begin
        if (acc && in_sbit && !in_dbit && !in_fault) m_ovf = 1;
        if (scrub_rdy) m_sreq = 0;
      end
`endif
    end
  end

  // Compare every cycle, mid-period, once the model has seen a reset.
  always @(negedge clk) begin
    if (live) begin
      chk("in_rdy", 128'(in_rdy), 128'(!rst && q.size() < 2));
      chk("out_vld", 128'(out_vld), 128'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_data", 128'(out_data), 128'(q[0].data));
        chk("out_err", 128'(out_err), 128'(q[0].err));
      end
      chk("sbit_cnt", 128'(sbit_cnt), 128'(m_sbit));
      chk("dbit_cnt", 128'(dbit_cnt), 128'(m_dbit));
      chk("fault_cnt", 128'(fault_cnt), 128'(m_fault));
      chk("first_vld", 128'(first_vld), 128'(m_first_vld));
      chk("first_addr", 128'(first_addr), 128'(m_first_addr));
      chk("irq", 128'(irq), 128'(m_first_vld));
`ifdef ECC_73_SCRUB_EN
      chk("scrub_vld", 128'(scrub_vld), 128'(m_sreq));
      chk("scrub_ovf", 128'(scrub_ovf), 128'(m_ovf));
      if (m_sreq) begin
        chk("scrub_addr", 128'(scrub_addr), 128'(m_saddr));
        chk("scrub_data", 128'(scrub_data), 128'(m_sdata));
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input bit s, input bit db, input bit f);
    bit done = 0;
    in_vld = 1'b1; in_data = d; in_addr = a; in_sbit = s; in_dbit = db; in_fault = f;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        @(posedge clk);
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 128'(0), 128'(1));
    #1 in_vld = 1'b0; in_sbit = 1'b0; in_dbit = 1'b0; in_fault = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_out_vld", 128'(out_vld), 128'(0));
    chk("rst_in_rdy", 128'(in_rdy), 128'(1));
    chk("rst_sbit_cnt", 128'(sbit_cnt), 128'(0));
    chk("rst_first_vld", 128'(first_vld), 128'(0));
    @(posedge clk); #1;

    // 8 back-to-back clean beats, out_rdy high
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(rnd_data(), AW'(i), 0, 0, 0);
    idle(2);
    chk("clean_sbit_cnt", 128'(sbit_cnt), 128'(0));
    chk("clean_dbit_cnt", 128'(dbit_cnt), 128'(0));
    chk("clean_fault_cnt", 128'(fault_cnt), 128'(0));

    // Downstream stall for 5 cycles: buffer fills after 2 beats
    out_rdy = 1'b0;
    send(rnd_data(), AW'(20), 0, 0, 0);
    send(rnd_data(), AW'(21), 0, 0, 0);
    @(negedge clk);
    chk("stall_in_rdy_low", 128'(in_rdy), 128'(0));
    chk("stall_out_vld", 128'(out_vld), 128'(1));
    idle(3);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(rnd_data(), AW'(22 + i), 0, 0, 0);
    idle(3);
    chk("stall_drained", 128'(out_vld), 128'(0));

    // dbit at 0x05 then fault at 0x0A
    do_reset();
    send(rnd_data(), AW'('h05), 0, 1, 0);
    @(negedge clk);
    chk("dbit_out_err", 128'(out_err), 128'(1));
    @(posedge clk); #1;
    send(rnd_data(), AW'('h0A), 0, 0, 1);
    @(negedge clk);
    chk("fault_out_err", 128'(out_err), 128'(1));
    @(posedge clk); #1;
    chk("first_addr_05", 128'(first_addr), 128'('h05));
    chk("irq_set", 128'(irq), 128'(1));
    chk("dbit_cnt_1", 128'(dbit_cnt), 128'(1));
    chk("fault_cnt_1", 128'(fault_cnt), 128'(1));

    // Saturation at 4 bits, then clr coincident with an sbit beat
    do_reset();
    for (int i = 0; i < 20; i++) send(rnd_data(), AW'(i), 1, 0, 0);
    idle(2);
    chk("sbit_sat_F", 128'(sbit_cnt), 128'('hF));
    clr = 1'b1;
    send(rnd_data(), AW'(1), 1, 0, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("sbit_after_clr", 128'(sbit_cnt), 128'(1));
    @(posedge clk); #1;

`ifdef ECC_73_SCRUB_EN
    // Scrub request held while scrub_rdy low; second candidate overflows
    do_reset();
    scrub_rdy = 1'b0;
    send(rnd_data(), AW'('h03), 1, 0, 0);
    idle(1);
    send(rnd_data(), AW'('h04), 1, 0, 0);
    idle(1);
    @(negedge clk);
    chk("scrub_vld_held", 128'(scrub_vld), 128'(1));
    chk("scrub_addr_03", 128'(scrub_addr), 128'('h03));
    chk("scrub_ovf_set", 128'(scrub_ovf), 128'(1));
    @(posedge clk); #1 scrub_rdy = 1'b1;
    @(posedge clk); #1 scrub_rdy = 1'b0;
    @(negedge clk);
    chk("scrub_idle", 128'(scrub_vld), 128'(0));
    @(posedge clk); #1;
`endif

    // Reset mid-operation with 2 buffered beats (and a pending scrub in that build)
    do_reset();
    out_rdy = 1'b0;
    send(rnd_data(), AW'(7), 1, 0, 0);
    send(rnd_data(), AW'(8), 0, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_rdy", 128'(in_rdy), 128'(0));
    chk("midrst_out_vld", 128'(out_vld), 128'(0));
    chk("midrst_out_data", 128'(out_data), 128'(0));
    chk("midrst_out_err", 128'(out_err), 128'(0));
    chk("midrst_sbit_cnt", 128'(sbit_cnt), 128'(0));
    chk("midrst_dbit_cnt", 128'(dbit_cnt), 128'(0));
    chk("midrst_first_addr", 128'(first_addr), 128'(0));
    chk("midrst_irq", 128'(irq), 128'(0));
`ifdef ECC_73_SCRUB_EN
    chk("midrst_scrub_vld", 128'(scrub_vld), 128'(0));
    chk("midrst_scrub_ovf", 128'(scrub_ovf), 128'(0));
`endif
    @(posedge clk); #1 rst = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("postrst_in_rdy", 128'(in_rdy), 128'(1));

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_vld   = ($urandom_range(0, 3) != 0);
      in_data  = rnd_data();
      in_addr  = AW'($urandom());
      in_sbit  = ($urandom_range(0, 2) == 0);
      in_dbit  = ($urandom_range(0, 9) == 0);
      in_fault = ($urandom_range(0, 12) == 0);
      out_rdy  = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 39) == 0);
`ifdef ECC_73_SCRUB_EN
      scrub_rdy = ($urandom_range(0, 2) == 0);
`endif
      if (c == 300) rst = 1'b1;
      if (c == 302) rst = 1'b0;
    end
    @(posedge clk); #1;
    in_vld = 1'b0; clr = 1'b0; out_rdy = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
